// File: rtl/busy_perf_counter.sv
// busy_perf_counter
//   Multi-channel utilisation counter. While the run window is open, every
//   clock adds one to the elapsed-cycle counter, and each channel counter
//   gains one when that channel's busy line is high. The host captures a
//   coherent snapshot of all counters and reads it back by index.
//
// Parameters
//   NUM_CH  number of busy channels (1..16)
//   CNT_W   width of every counter and of rd_data (8..128)
//   SEL_W   derived select width, $clog2(NUM_CH+1)
//
// Ports
//   clock       single clock, posedge
//   reset_n     asynchronous active-low reset
//   start       open or resume the run window
//   stop        close the run window
//   clear       zero live counts and ovf, return to IDLE
//   busy        per-channel busy lines
//   snap_req    capture all live counts into the snapshot bank
//   rd_sel      0..NUM_CH-1 selects a channel, NUM_CH selects the cycle count
//   rd_data     registered snapshot[rd_sel], zero for out-of-range selects
//   snap_valid  one-cycle pulse after the snapshot bank is loaded
//   running     high while the FSM is in RUN
//   ovf         sticky overflow flags, bit NUM_CH belongs to the cycle counter
//
// Configuration
//   BUSY_PERF_COUNTER_SAT_EN  when defined, counters saturate at all-ones
//                             instead of wrapping; ovf still sets.

module busy_perf_counter #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 64,
  localparam int SEL_W = $clog2(NUM_CH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [NUM_CH-1:0] busy,
  input  logic              snap_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              snap_valid,
  output logic              running,
  output logic [NUM_CH:0]   ovf
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CH);

  state_t           state;
  logic [CNT_W-1:0] cnt  [NUM_CH+1];
  logic [CNT_W-1:0] bank [NUM_CH+1];
  logic [NUM_CH:0]  inc_vec;

  // Entry NUM_CH is the elapsed-cycle counter, which increments every RUN cycle.
  assign inc_vec = {1'b1, busy};

  // Run-window FSM; running is registered alongside the state so it is high
  // exactly on the cycles that count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        HALT: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Live counters. Counting depends on the state before the edge, so the
  // edge leaving RUN still counts and the edge entering RUN does not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= '0;
      for (int i = 0; i <= NUM_CH; i++) cnt[i] <= '0;
    end else if (clear) begin
      ovf <= '0;
      for (int i = 0; i <= NUM_CH; i++) cnt[i] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        if (inc_vec[i]) begin
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
`ifdef BUSY_PERF_COUNTER_SAT_EN
            cnt[i] <= cnt[i];
`else
            cnt[i] <= '0;
`endif
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Snapshot bank and readout. The bank takes pre-increment (and pre-clear)
  // live values; a read in the same cycle as a bank load returns the old entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_valid <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i <= NUM_CH; i++) bank[i] <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        for (int i = 0; i <= NUM_CH; i++) bank[i] <= cnt[i];
      end
      if (rd_sel <= MAX_SEL) begin
        rd_data <= bank[rd_sel];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule
